dispense_mode_arbiter: RTL

- Owns the select line of the dispenser's controller/maintenance input mux and gates the start strobes that feed it.
- Switches mode only after the dispenser has been idle for a settle window, so no dispense is cut off mid-operation.
- Auto-returns from maintenance after an inactivity timeout.
- Sits between the user controller, the maintenance keyswitch/panel and the colour/start mux.

---
 rtl/dispense_mode_arbiter_if.sv | 26 ++
 rtl/dispense_mode_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/dispense_mode_arbiter_if.sv
// Signal bundle between the dispenser mode arbiter and its surroundings:
// the mode/start inputs from the controller and maintenance panel, and the mux-side outputs.
interface dispense_mode_arbiter_if;
    logic maint_req;
    logic dispenser_busy;
    logic controller_start;
    logic maintenance_start;
    logic select;
    logic ctrl_start_gated;
    logic maint_start_gated;
    logic switching;
    logic start_dropped;
    logic timeout_pulse;

    modport master (
        output maint_req, dispenser_busy, controller_start, maintenance_start,
        input  select, ctrl_start_gated, maint_start_gated, switching,
               start_dropped, timeout_pulse
    );

    modport slave (
        input  maint_req, dispenser_busy, controller_start, maintenance_start,
        output select, ctrl_start_gated, maint_start_gated, switching,
               start_dropped, timeout_pulse
    );
endinterface

// File: rtl/dispense_mode_arbiter.sv
// Drives the controller/maintenance mux select for the dispenser. The select only changes
// after the mechanism has settled idle, and maintenance mode returns automatically after a period of inactivity.
module dispense_mode_arbiter #(
    parameter int SETTLE_CYCLES = 4,
    parameter int IDLE_TIMEOUT  = 1000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    dispense_mode_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        CTRL,
        DRAIN_TO_MAINT,
        MAINT,
        DRAIN_TO_CTRL
    } state_t;

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_LAST   = IW'(IDLE_TIMEOUT - 1);

    state_t        state, state_nx;
    logic [SW-1:0] settle_cnt, settle_nx;
    logic [IW-1:0] idle_cnt, idle_nx;
    logic          pending, pending_nx;
    logic          armed, armed_nx;
    logic          ctrl_g_nx, maint_g_nx, dropped_nx, timeout_nx;
    logic          settle_done, maint_idle, idle_done;

    assign settle_done = (settle_cnt == SETTLE_LAST) && !bus.dispenser_busy;
    assign maint_idle  = !bus.maintenance_start && !bus.dispenser_busy;
    assign idle_done   = maint_idle && (idle_cnt == IDLE_LAST);

    always_comb begin
        state_nx   = state;
        pending_nx = pending;
        armed_nx   = armed;
        ctrl_g_nx  = 1'b0;
        maint_g_nx = 1'b0;
        dropped_nx = 1'b0;
        timeout_nx = 1'b0;
        idle_nx    = '0;
        settle_nx  = '0;

        case (state)
            CTRL: begin
                ctrl_g_nx = bus.controller_start;
                if (!bus.maint_req) begin
                    armed_nx = 1'b1;
                end else if (armed) begin
                    state_nx = DRAIN_TO_MAINT;
                end
            end

            DRAIN_TO_MAINT: begin
                dropped_nx = bus.controller_start | bus.maintenance_start;
                if (!bus.maint_req) begin
                    state_nx = CTRL;
                end else if (settle_done) begin
                    state_nx = MAINT;
                end
            end

            MAINT: begin
                maint_g_nx = bus.maintenance_start;
                dropped_nx = bus.controller_start;
                if (maint_idle) begin
                    idle_nx = (idle_cnt != IDLE_LAST) ? idle_cnt + IW'(1) : idle_cnt;
                end
                // Timeout wins over a simultaneous keyswitch release so the pulse is never lost.
                if (idle_done) begin
                    state_nx   = DRAIN_TO_CTRL;
                    timeout_nx = 1'b1;
                    armed_nx   = 1'b0;
                end else if (!bus.maint_req) begin
                    state_nx = DRAIN_TO_CTRL;
                end
            end

            DRAIN_TO_CTRL: begin
                dropped_nx = bus.maintenance_start | (bus.controller_start & pending);
                if (bus.controller_start) begin
                    pending_nx = 1'b1;
                end
                // A held controller start is released into the first cycle back in controller mode.
                if (settle_done) begin
                    state_nx   = CTRL;
                    ctrl_g_nx  = pending | bus.controller_start;
                    pending_nx = 1'b0;
                end
            end

            default: state_nx = CTRL;
        endcase

        if (state_nx != MAINT) begin
            idle_nx = '0;
        end

        if ((state_nx != state) || bus.dispenser_busy) begin
            settle_nx = '0;
        end else if (settle_cnt != SETTLE_LAST) begin
            settle_nx = settle_cnt + SW'(1);
        end else begin
            settle_nx = settle_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= CTRL;
            settle_cnt            <= '0;
            idle_cnt              <= '0;
            pending               <= 1'b0;
            armed                 <= 1'b1;
            bus.select            <= 1'b0;
            bus.switching         <= 1'b0;
            bus.ctrl_start_gated  <= 1'b0;
            bus.maint_start_gated <= 1'b0;
            bus.start_dropped     <= 1'b0;
            bus.timeout_pulse     <= 1'b0;
        end else begin
            state                 <= state_nx;
            settle_cnt            <= settle_nx;
            idle_cnt              <= idle_nx;
            pending               <= pending_nx;
            armed                 <= armed_nx;
            bus.select            <= (state_nx == MAINT) || (state_nx == DRAIN_TO_CTRL);
            bus.switching         <= (state_nx == DRAIN_TO_MAINT) || (state_nx == DRAIN_TO_CTRL);
            bus.ctrl_start_gated  <= ctrl_g_nx;
            bus.maint_start_gated <= maint_g_nx;
            bus.start_dropped     <= dropped_nx;
            bus.timeout_pulse     <= timeout_nx;
        end
    end

endmodule
